// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_pkg
// Brief    : Shared defaults, range type and range clamp helper for the
//            frequency meter front end.
// Revision : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    localparam int FREQ_RATIO_DEFAULT   = 10;
    localparam int FREQ_STAGES_DEFAULT  = 3;
    localparam int FREQ_RANGE_W_DEFAULT = $clog2(FREQ_STAGES_DEFAULT + 1);

    typedef logic [FREQ_RANGE_W_DEFAULT-1:0] range_t;

    function automatic int unsigned clamp_range(input int unsigned req,
                                                input int unsigned max_range);
        return (req > max_range) ? max_range : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_prescaler_if.sv
`default_nettype none
// ============================================================================
// Module   : freq_prescaler_if
// Brief    : Measured-signal / range-select / strobe bundle of the prescaler.
// Revision : 1.0 - initial release
// ============================================================================
interface freq_prescaler_if
    import freq_meter_pkg::*;
#(
    parameter int STAGES = FREQ_STAGES_DEFAULT
);
    localparam int RANGE_W = $clog2(STAGES + 1);

    logic               signal;
    logic [RANGE_W-1:0] range;
    logic               out_pulse;
    logic               out_level;
    logic               range_chg;

    modport master (
        output signal,
        output range,
        input  out_pulse,
        input  out_level,
        input  range_chg
    );

    modport slave (
        input  signal,
        input  range,
        output out_pulse,
        output out_level,
        output range_chg
    );

endinterface
`default_nettype wire

// File: rtl/freq_prescaler_stage.sv
`default_nettype none
// ============================================================================
// Module   : prescale_stage
// Brief    : One modulo-RATIO counter stage of the prescaler cascade.
// Revision : 1.0 - initial release
// ============================================================================
module prescale_stage #(
    parameter int RATIO = 10
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     clr,
    input  wire logic                     inc,
    output logic [$clog2(RATIO)-1:0]      cnt,
    output logic                          carry
);
    localparam int                 CNT_W   = $clog2(RATIO);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        end
    end

    assign cnt   = r_cnt;
    assign carry = inc & (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/freq_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : freq_prescaler
// Brief    : Synchronised rising-edge divider by RATIO^range with strobe and
//            toggle outputs. Optional FREQ_PRESCALER_DEGLITCH_EN adds a
//            3-sample majority filter ahead of the edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module freq_prescaler
    import freq_meter_pkg::*;
#(
    parameter int RATIO  = FREQ_RATIO_DEFAULT,
    parameter int STAGES = FREQ_STAGES_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    freq_prescaler_if.slave  bus
);
    localparam int RANGE_W = $clog2(STAGES + 1);
    localparam int CNT_W   = $clog2(RATIO);

    logic [1:0]         r_sync;
    logic               r_level_d;
    logic               w_level;
    logic               w_edge;
    logic [RANGE_W-1:0] r_range_q;
    logic [RANGE_W-1:0] w_range_cl;
    logic               w_chg;
    logic               w_all_max;
    logic               w_hit;
    logic               r_pulse;
    logic               r_level;
    logic               r_chg;
    logic [STAGES-1:0]  w_inc;
    logic [STAGES-1:0]  w_clr;
    logic [STAGES-1:0]  w_carry;
    logic [CNT_W-1:0]   w_cnt [STAGES];
    logic               w_unused_top_carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], bus.signal};
        end
    end

`ifdef FREQ_PRESCALER_DEGLITCH_EN
    // Window is the live s2 plus its two previous samples; 2-of-3 vote.
    logic [1:0] r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else begin
            r_hist <= {r_hist[0], r_sync[1]};
        end
    end

    assign w_level = (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) |
                     (r_hist[0] & r_hist[1]);
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign w_edge     = w_level & ~r_level_d;
    assign w_range_cl = RANGE_W'(clamp_range(32'(bus.range), STAGES));
    assign w_chg      = (w_range_cl != r_range_q);

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_first
            assign w_inc[i] = w_edge & ~w_chg;
        end else begin : g_next
            assign w_inc[i] = w_carry[i-1];
        end

        // Stages beyond the selected range stay parked at zero.
        assign w_clr[i] = w_chg | (r_range_q <= RANGE_W'(i));

        prescale_stage #(
            .RATIO (RATIO)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_clr[i]),
            .inc   (w_inc[i]),
            .cnt   (w_cnt[i]),
            .carry (w_carry[i])
        );
    end

    // The top stage's carry has no consumer; hit is decoded from the counts.
    assign w_unused_top_carry = w_carry[STAGES-1];

    always_comb begin
        w_all_max = 1'b1;
        for (int j = 0; j < STAGES; j++) begin
            if (RANGE_W'(j) < r_range_q) begin
                w_all_max = w_all_max & (w_cnt[j] == CNT_W'(RATIO - 1));
            end
        end
    end

    assign w_hit = w_edge & ~w_chg & w_all_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_range_q <= '0;
            r_pulse   <= 1'b0;
            r_level   <= 1'b0;
            r_chg     <= 1'b0;
        end else begin
            r_range_q <= w_range_cl;
            r_pulse   <= w_hit;
            r_level   <= r_level ^ w_hit;
            r_chg     <= w_chg;
        end
    end

    assign bus.out_pulse = r_pulse;
    assign bus.out_level = r_level;
    assign bus.range_chg = r_chg;

endmodule
`default_nettype wire
